pc_seq_unit: RTL and testbench
==============================

Name: pc_seq_unit

Overview:
Parametrised program-counter unit for the MIPS fetch stage; next-generation PC register with configurable width/increment.
Adds a boot state, branch/jump redirect, exception vectoring with EPC capture, stall hold and a small return-address stack (RAS) for call/return prediction.
Sits between next-PC selection in decode/execute and the instruction-memory address port.

Parameters:
WIDTH, 32, PC and address width in bits
INC, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address stack entries (>=2)
EXC_VECTOR, 32'h80000180, PC loaded on exception (truncated to WIDTH)
ALIGN_BITS, 2, low address bits that must be zero

Ports:
CLK  in  1  clock, rising-edge active
Reset  in  1  asynchronous, active-high reset
startPC  in  WIDTH  boot address, loaded on first edge after reset release
PC_write  in  1  1 = advance sequentially, 0 = stall/hold
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  WIDTH  redirect destination
exc_req  in  1  exception request
call_push  in  1  push pc+INC onto RAS
ret_pop  in  1  return: pop RAS into pc
pc  out  WIDTH  current PC (registered)
pc_seq  out  WIDTH  pc+INC, combinational, mod 2^WIDTH
epc  out  WIDTH  PC captured at last exception
ras_top  out  WIDTH  top RAS entry (0 when empty)
ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries
ras_empty / ras_full  out  1  RAS status
misaligned  out  1  one-cycle pulse: last redirect had nonzero low bits
running  out  1  1 in RUN state

Behaviour:
- Reset asserted (async, immediate, also mid-operation): pc=0, epc=0, RAS cleared (count 0, ras_top 0), misaligned=0, state=BOOT, running=0.
- FSM BOOT -> RUN on first rising edge with Reset low: pc<=startPC; all other inputs ignored that edge. RUN persists until Reset.
- RUN, per rising edge, pc update priority:
  1. exc_req: epc<=pc, pc<=EXC_VECTOR.
  2. redirect_valid: pc<=redirect_target with low ALIGN_BITS forced 0; misaligned<=1 if any were set.
  3. ret_pop && !ras_empty: pc<=ras_top.
  4. PC_write: pc<=pc_seq.
  5. otherwise hold.
- exc_req and redirect_valid ignore PC_write (stall never blocks them). misaligned is 0 on every edge without a misaligned redirect.
- Sequential add wraps: pc=2^WIDTH-INC with PC_write -> 0.
- RAS, RUN only, suppressed entirely when exc_req=1:
  - call_push pushes the current pc_seq; normally paired with redirect_valid (the call's jump).
  - Push when full: oldest entry overwritten (circular); count stays RAS_DEPTH.
  - Pop when empty: no stack change; pc follows priorities 4/5.
  - Simultaneous push+pop: pc<=old top (if pop is selected), top entry replaced by new value, count unchanged.
  - A pop whose pc update is pre-empted by redirect_valid still removes the entry.
- Latency: every pc change is visible one edge after its request; pc_seq follows pc combinationally.

Decomposition:
- Shared include pc_defs.vh: default WIDTH, INC, EXC_VECTOR, BOOT/RUN state encodings, clog2 function.
- Sub-module pc_ras: circular-buffer return-address stack (push/pop/top/count/full/empty, async reset), parametrised by WIDTH and RAS_DEPTH.
- pc_seq_unit holds the FSM, priority mux, EPC and misaligned registers.

Test Plan:
- Reset=1, startPC=0x100 -> pc=0, running=0 immediately. Release, one edge -> pc=0x100, running=1.
- PC_write=0 for 2 edges -> pc stays 0x100. PC_write=1 for 2 edges -> 0x104, then 0x108. pc=0xFFFFFFFC with PC_write -> 0x0.
- PC_write=0, redirect 0x2000 -> pc=0x2000, misaligned=0. Redirect 0x2002 -> pc=0x2000, misaligned=1 for exactly one cycle.
- At pc=0x108: call_push + redirect 0x400 -> pc=0x400, ras_count=1, ras_top=0x10C. Then ret_pop -> pc=0x10C, ras_empty=1.
- DEPTH=4, 5 pushes of A..E -> ras_full=1, count=4. 4 pops return E, D, C, B. 5th pop with PC_write=1 -> sequential pc, count stays 0.
- At pc=0x500: exc_req + redirect + call_push -> pc=0x80000180, epc=0x500, RAS unchanged. Assert Reset mid-run between edges -> pc=0 and RAS empty without a clock edge.

Source files
------------

// File: rtl/pc_seq_unit_pkg.sv
// Shared defaults, FSM state encoding and a width helper for the PC sequencing unit.
package pc_seq_unit_pkg;

    localparam int          DEF_WIDTH      = 32;
    localparam int          DEF_INC        = 4;
    localparam int          DEF_RAS_DEPTH  = 4;
    localparam int          DEF_ALIGN_BITS = 2;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    // Bits needed to hold values 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular-buffer return-address stack: a full push overwrites the oldest entry.
module pc_ras
    import pc_seq_unit_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                              CLK,
    input  logic                              Reset,
    input  logic                              push,
    input  logic                              pop,
    input  logic [WIDTH-1:0]                  push_data,
    output logic [WIDTH-1:0]                  top,
    output logic [clog2(RAS_DEPTH+1)-1:0]     count,
    output logic                              empty,
    output logic                              full
);

    localparam int PW = clog2(RAS_DEPTH);
    localparam int CW = clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;        // next free slot; ptr-1 is the top
    logic [PW-1:0]    ptr_last;
    logic [PW-1:0]    ptr_next;
    logic             pop_eff;

    assign empty    = (count == '0);
    assign full     = (count == CW'(RAS_DEPTH));
    assign pop_eff  = pop && !empty;
    assign ptr_last = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);
    assign ptr_next = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + PW'(1);
    assign top      = empty ? '0 : mem[ptr_last];

    // NOTE: the entry array has no reset; count==0 already masks stale contents.
    always_ff @(posedge CLK) begin
        if (push) mem[pop_eff ? ptr_last : ptr] <= push_data;
    end

    always_ff @(posedge Reset or posedge CLK) begin
        if (Reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop_eff) begin
            // Top entry is replaced in place; depth is unchanged.
        end else if (push) begin
            ptr   <= ptr_next;
            count <= full ? count : count + CW'(1);
        end else if (pop_eff) begin
            ptr   <= ptr_last;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program counter: boot load, exception vectoring with EPC,
// aligned redirects, return-address prediction and stall hold.
module pc_seq_unit
    import pc_seq_unit_pkg::*;
#(
    parameter int          WIDTH      = DEF_WIDTH,
    parameter int          INC        = DEF_INC,
    parameter int          RAS_DEPTH  = DEF_RAS_DEPTH,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int          ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic [WIDTH-1:0]              startPC,
    input  logic                          PC_write,
    input  logic                          redirect_valid,
    input  logic [WIDTH-1:0]              redirect_target,
    input  logic                          exc_req,
    input  logic                          call_push,
    input  logic                          ret_pop,
    output logic [WIDTH-1:0]              pc,
    output logic [WIDTH-1:0]              pc_seq,
    output logic [WIDTH-1:0]              epc,
    output logic [WIDTH-1:0]              ras_top,
    output logic [clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                          ras_empty,
    output logic                          ras_full,
    output logic                          misaligned,
    output logic                          running
);

    localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    pc_state_e state;
    logic      ras_push;
    logic      ras_pop;

    assign pc_seq = pc + WIDTH'(INC);

    // An exception squashes any call/return in the same cycle.
    assign ras_push = running && !exc_req && call_push;
    assign ras_pop  = running && !exc_req && ret_pop;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .Reset     (Reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= BOOT;
            pc         <= '0;
            epc        <= '0;
            misaligned <= 1'b0;
            running    <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            case (state)
                BOOT: begin
                    pc      <= startPC;
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: begin
                    if (exc_req) begin
                        epc <= pc;
                        pc  <= EXC_PC;
                    end else if (redirect_valid) begin
                        pc         <= redirect_target & ~ALIGN_MASK;
                        misaligned <= |(redirect_target & ALIGN_MASK);
                    end else if (ret_pop && !ras_empty) begin
                        pc <= ras_top;
                    end else if (PC_write) begin
                        pc <= pc_seq;
                    end
                end
                default: begin
                    state   <= BOOT;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed table, RAS depth sequence, reset, random vs. model.
module tb_pc_seq_unit;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] startPC;
    logic        PC_write, redirect_valid, exc_req, call_push, ret_pop;
    logic [31:0] redirect_target;
    logic [31:0] pc, pc_seq, epc, ras_top;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, misaligned, running;

    int total = 0;
    int bad   = 0;

    pc_seq_unit dut (
        .CLK             (CLK),
        .Reset           (Reset),
        .startPC         (startPC),
        .PC_write        (PC_write),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_req         (exc_req),
        .call_push       (call_push),
        .ret_pop         (ret_pop),
        .pc              (pc),
        .pc_seq          (pc_seq),
        .epc             (epc),
        .ras_top         (ras_top),
        .ras_count       (ras_count),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .misaligned      (misaligned),
        .running         (running)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        pw, rv, exc, push, pop;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [2:0]  e_cnt;
        logic [31:0] e_top;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[20];

    // Reference model: a plain queue whose back is the top of the stack.
    logic [31:0] m_pc, m_epc;
    logic        m_mis, m_run;
    logic [31:0] m_stk[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic pw, input logic rv, input logic [31:0] tgt,
                         input logic exc, input logic push, input logic pop);
        PC_write        = pw;
        redirect_valid  = rv;
        redirect_target = tgt;
        exc_req         = exc;
        call_push       = push;
        ret_pop         = pop;
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_epc = '0;
        m_mis = 1'b0;
        m_run = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step();
        logic [31:0] old_pc, top;
        bit can_pop;
        if (!m_run) begin
            m_pc  = startPC;
            m_run = 1'b1;
            m_mis = 1'b0;
            return;
        end
        old_pc  = m_pc;
        can_pop = (m_stk.size() > 0);
        top     = can_pop ? m_stk[$] : 32'd0;
        m_mis   = 1'b0;
        if (exc_req) begin
            m_epc = m_pc;
            m_pc  = EXC;
        end else begin
            if (redirect_valid) begin
                m_pc  = {redirect_target[31:2], 2'b00};
                m_mis = (redirect_target[1:0] != 2'b00);
            end else if (ret_pop && can_pop) begin
                m_pc = top;
            end else if (PC_write) begin
                m_pc = m_pc + 32'd4;
            end
            if (ret_pop && can_pop) void'(m_stk.pop_back());
            if (call_push) begin
                if (m_stk.size() == 4) void'(m_stk.pop_front());
                m_stk.push_back(old_pc + 32'd4);
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] etop;
        etop = (m_stk.size() > 0) ? m_stk[$] : 32'd0;
        check({tag, "_pc"},      pc, m_pc);
        check({tag, "_pc_seq"},  pc_seq, m_pc + 32'd4);
        check({tag, "_epc"},     epc, m_epc);
        check({tag, "_mis"},     32'(misaligned), 32'(m_mis));
        check({tag, "_run"},     32'(running), 32'(m_run));
        check({tag, "_cnt"},     32'(ras_count), 32'(m_stk.size()));
        check({tag, "_top"},     ras_top, etop);
        check({tag, "_empty"},   32'(ras_empty), 32'(m_stk.size() == 0));
        check({tag, "_full"},    32'(ras_full), 32'(m_stk.size() == 4));
    endtask

    function automatic vec_t mk(input logic pw, input logic rv, input logic [31:0] tgt,
                                input logic exc, input logic push, input logic pop,
                                input logic [31:0] e_pc, input logic e_mis, input logic [2:0] e_cnt,
                                input logic [31:0] e_top, input logic [31:0] e_epc);
        vec_t v;
        v.pw = pw; v.rv = rv; v.tgt = tgt; v.exc = exc; v.push = push; v.pop = pop;
        v.e_pc = e_pc; v.e_mis = e_mis; v.e_cnt = e_cnt; v.e_top = e_top; v.e_epc = e_epc;
        return v;
    endfunction

    initial begin
        //            pw rv tgt            exc push pop  pc            mis cnt top        epc
        vecs[0]  = mk(0, 0, 32'h0,         0,  0,   0,   32'h100,      0,  0,  32'h0,     32'h0);
        vecs[1]  = mk(0, 0, 32'h0,         0,  0,   0,   32'h100,      0,  0,  32'h0,     32'h0);
        vecs[2]  = mk(1, 0, 32'h0,         0,  0,   0,   32'h104,      0,  0,  32'h0,     32'h0);
        vecs[3]  = mk(1, 0, 32'h0,         0,  0,   0,   32'h108,      0,  0,  32'h0,     32'h0);
        vecs[4]  = mk(0, 1, 32'h400,       0,  1,   0,   32'h400,      0,  1,  32'h10C,   32'h0);
        vecs[5]  = mk(0, 0, 32'h0,         0,  0,   1,   32'h10C,      0,  0,  32'h0,     32'h0);
        vecs[6]  = mk(0, 1, 32'h2000,      0,  0,   0,   32'h2000,     0,  0,  32'h0,     32'h0);
        vecs[7]  = mk(0, 1, 32'h2002,      0,  0,   0,   32'h2000,     1,  0,  32'h0,     32'h0);
        vecs[8]  = mk(0, 0, 32'h0,         0,  0,   0,   32'h2000,     0,  0,  32'h0,     32'h0);
        vecs[9]  = mk(0, 1, 32'hFFFFFFFC,  0,  0,   0,   32'hFFFFFFFC, 0,  0,  32'h0,     32'h0);
        vecs[10] = mk(1, 0, 32'h0,         0,  0,   0,   32'h0,        0,  0,  32'h0,     32'h0);
        vecs[11] = mk(0, 1, 32'h500,       0,  0,   0,   32'h500,      0,  0,  32'h0,     32'h0);
        vecs[12] = mk(0, 0, 32'h0,         0,  1,   0,   32'h500,      0,  1,  32'h504,   32'h0);
        vecs[13] = mk(0, 1, 32'h700,       1,  1,   0,   EXC,          0,  1,  32'h504,   32'h500);
        vecs[14] = mk(0, 1, 32'h900,       0,  0,   1,   32'h900,      0,  0,  32'h0,     32'h500);
        vecs[15] = mk(0, 1, 32'hA00,       0,  1,   0,   32'hA00,      0,  1,  32'h904,   32'h500);
        vecs[16] = mk(0, 0, 32'h0,         0,  1,   1,   32'h904,      0,  1,  32'hA04,   32'h500);
        vecs[17] = mk(0, 0, 32'h0,         1,  0,   1,   EXC,          0,  1,  32'hA04,   32'h904);
        vecs[18] = mk(0, 0, 32'h0,         0,  0,   1,   32'hA04,      0,  0,  32'h0,     32'h904);
        vecs[19] = mk(1, 0, 32'h0,         0,  0,   1,   32'hA08,      0,  0,  32'h0,     32'h904);

        // Reset state, visible without any clock edge.
        Reset   = 1'b1;
        startPC = 32'h100;
        drive(1, 1, 32'h3000, 1, 1, 1);
        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_run", 32'(running), 32'd0);
        check("rst_cnt", 32'(ras_count), 32'd0);
        check("rst_top", ras_top, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_mis", 32'(misaligned), 32'd0);
        #10;
        Reset = 1'b0;
        step();
        check("boot_pc", pc, 32'h100);
        check("boot_run", 32'(running), 32'd1);
        check("boot_cnt", 32'(ras_count), 32'd0);
        check("boot_epc", epc, 32'h0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].pw, vecs[i].rv, vecs[i].tgt, vecs[i].exc, vecs[i].push, vecs[i].pop);
            step();
            check($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("vec%0d_mis", i), 32'(misaligned), 32'(vecs[i].e_mis));
            check($sformatf("vec%0d_cnt", i), 32'(ras_count), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d_top", i), ras_top, vecs[i].e_top);
            check($sformatf("vec%0d_epc", i), epc, vecs[i].e_epc);
        end

        // Depth: five calls into a four-entry stack, then unwind.
        drive(0, 1, 32'h10000, 0, 0, 0);
        step();
        check("dep_start", pc, 32'h10000);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 32'h10000 + 32'h100 * 32'(i + 1), 0, 1, 0);
            step();
        end
        check("dep_full", 32'(ras_full), 32'd1);
        check("dep_cnt4", 32'(ras_count), 32'd4);
        check("dep_top", ras_top, 32'h10404);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 32'h0, 0, 0, 1);
            step();
            check($sformatf("dep_pop%0d", i), pc, 32'h10404 - 32'h100 * 32'(i));
        end
        drive(1, 0, 32'h0, 0, 0, 1);
        step();
        check("dep_pop_empty_pc", pc, 32'h10108);
        check("dep_pop_empty_cnt", 32'(ras_count), 32'd0);
        check("dep_pop_empty_flag", 32'(ras_empty), 32'd1);

        // Mid-run reset between edges: takes effect with no clock.
        drive(0, 1, 32'h600, 0, 1, 0);
        step();
        #3;
        Reset = 1'b1;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_cnt", 32'(ras_count), 32'd0);
        check("midrst_empty", 32'(ras_empty), 32'd1);
        check("midrst_run", 32'(running), 32'd0);
        #2;
        Reset = 1'b0;

        // Randomised run against the queue model from a fresh boot.
        model_reset();
        startPC = $urandom & 32'hFFFF_FFFC;
        for (int n = 0; n < 400; n++) begin
            PC_write        = 1'($urandom_range(0, 1));
            redirect_valid  = ($urandom_range(0, 3) == 0);
            redirect_target = $urandom;
            if ($urandom_range(0, 1) == 1) redirect_target[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) redirect_target = 32'hFFFF_FFF8;
            exc_req         = ($urandom_range(0, 15) == 0);
            call_push       = ($urandom_range(0, 2) == 0);
            ret_pop         = ($urandom_range(0, 3) == 0);
            model_step();
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
